adder_selftest_seq: RTL and testbench
=====================================

Name: adder_selftest_seq

Overview:
- Synthesizable exhaustive self-test sequencer wrapped around the flattened CMOS-gate `adder`.
- Upstream role: drives every operand pair onto the adder's X/Y inputs in index order.
- Downstream role: samples S/cout after a programmable settle time, compares against the golden X+Y, and accumulates an error count plus the first failing index.
- Replaces file-based vector checking on silicon/FPGA; the index order matches the team's test-vector file (X major, Y minor).

Parameters:
- WIDTH, 6, operand width of the adder under test.
- SETTLE_CYCLES, 1, clock cycles between applying operands and sampling the result (0 allowed).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a full sweep; sampled in IDLE or DONE only.
- x_o  out  WIDTH  operand X to the adder, registered.
- y_o  out  WIDTH  operand Y to the adder, registered.
- s_i  in  WIDTH  adder sum S.
- cout_i  in  1  adder carry out.
- busy  out  1  sweep in progress.
- done  out  1  level; high in DONE until the next start or reset.
- pass  out  1  valid when done; 1 iff err_count==0.
- err_count  out  2*WIDTH+1  number of mismatching vectors.
- first_err_valid  out  1  at least one mismatch recorded this sweep.
- first_err_idx  out  2*WIDTH  index {x,y} of the first mismatch.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0: x_o, y_o, busy, done, pass, err_count, first_err_valid, first_err_idx. The index and settle counters are also 0.
- Reset mid-sweep aborts immediately with the same values; no partial results are retained.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE / DONE:
  - start=1 -> APPLY.
  - On that transition: idx=0, err_count=0, first_err_valid=0, first_err_idx=0, done=0, pass=0.
- APPLY (1 cycle):
  - x_o<=idx[2W-1:W], y_o<=idx[W-1:0].
  - Next state is SETTLE if SETTLE_CYCLES>0, else CHECK.
- SETTLE: stays exactly SETTLE_CYCLES cycles, then -> CHECK.
- CHECK (1 cycle):
  - exp = {1'b0,x_o} + {1'b0,y_o}, W+1 bits.
  - Mismatch if {cout_i,s_i} != exp.
  - On mismatch: err_count++. If first_err_valid=0, latch first_err_idx=idx and set first_err_valid=1.
  - If idx == 2^(2W)-1: -> DONE. Otherwise idx++ and -> APPLY.
- Last vector:
  - idx never wraps within a sweep; the terminal compare is made on all-ones.
  - err_count width holds the maximum 2^(2W) mismatches, so no saturation is needed.
- Timing:
  - Per vector: 2+SETTLE_CYCLES cycles.
  - done rises exactly (2+SETTLE_CYCLES)*2^(2W) cycles after the clock edge that samples start.
- Outputs in DONE:
  - busy=0, done=1, pass=(err_count==0).
  - x_o/y_o hold the last vector.
- busy=1 in APPLY, SETTLE and CHECK.
- start is ignored while busy. start held high in DONE re-launches a sweep every completion.
- s_i/cout_i are used only in CHECK. The adder is purely combinational, so no input synchronization is needed.

Optional Feature:
- Macro: ADDER_SELFTEST_STOP_ON_ERR_EN.
- Defined: the first mismatch in CHECK goes directly to DONE instead of continuing. Results are then err_count=1, first_err_valid=1, pass=0, and x_o/y_o hold the failing vector.
- Undefined: full sweep always runs to completion, as described above.

Decomposition:
- Shared package `adder_selftest_pkg`:
  - state enum (IDLE, APPLY, SETTLE, CHECK, DONE);
  - localparam NUM_VEC = 2**(2*WIDTH);
  - golden-sum function.
- One natural sub-module, `adder_result_checker`:
  - combinational compare plus err_count / first-error registers;
  - enabled by a check strobe from the FSM.
- Top level holds the FSM and the index/settle counters, and instantiates `adder` for integration tests only. The block itself has ports to the adder, not an internal instance.

Test Plan:
- Correct adder, SETTLE_CYCLES=1, pulse start -> done after 12288 cycles; err_count=0, pass=1, first_err_valid=0.
- S[0] forced stuck-at-0 -> err_count=2048, first_err_idx=1 (x=0, y=1), pass=0.
- cout forced stuck-at-0 -> err_count=2016, first_err_idx=127 (x=1, y=63).
- rst_n low at cycle 5000 of a sweep, then start -> all outputs 0 during reset; the fresh sweep completes with err_count=0 after 12288 cycles.
- start pulsed while busy at cycle 100 -> no effect; done still at cycle 12288. Then start in DONE -> done drops next cycle, new sweep runs.
- With ADDER_SELFTEST_STOP_ON_ERR_EN and S[0] stuck-at-0 -> DONE after 6 cycles; err_count=1, x_o=0, y_o=1.

Source files
------------

// File: rtl/adder_selftest_pkg.sv
// Shared types and helpers for the exhaustive adder self-test sequencer.
package adder_selftest_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int WIDTH_DEF = 6;
  localparam int NUM_VEC   = 2 ** (2 * WIDTH_DEF);

  // Widest operand the golden-sum helper supports; narrower operands are zero-extended.
  localparam int MAX_WIDTH = 16;

  function automatic logic [MAX_WIDTH:0] golden_sum(input logic [MAX_WIDTH-1:0] a,
                                                    input logic [MAX_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/adder_selftest_seq_if.sv
// Operand/result bus between the self-test sequencer and the adder under test.
interface adder_selftest_seq_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] x_o;
  logic [WIDTH-1:0] y_o;
  logic [WIDTH-1:0] s_i;
  logic             cout_i;

  modport master (output x_o, output y_o, input s_i, input cout_i);
  modport slave  (input x_o, input y_o, output s_i, output cout_i);
endinterface

// File: rtl/adder_selftest_seq_result_checker.sv
// Golden compare of {cout,s} against x+y, error counter and first-failure capture.
// ADDER_SELFTEST_STOP_ON_ERR_EN: when defined, a mismatch raises stop_req for the FSM.
module adder_result_checker
  import adder_selftest_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               check_en,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [WIDTH-1:0]   s,
  input  logic               cout,
  input  logic [2*WIDTH-1:0] idx,
  output logic [2*WIDTH:0]   err_count,
  output logic               first_err_valid,
  output logic [2*WIDTH-1:0] first_err_idx,
  output logic               stop_req
);

  logic [MAX_WIDTH-1:0] x_ext;
  logic [MAX_WIDTH-1:0] y_ext;
  logic [MAX_WIDTH:0]   exp_sum;
  logic [MAX_WIDTH:0]   got_sum;
  logic                 mismatch;

  assign x_ext    = MAX_WIDTH'(x);
  assign y_ext    = MAX_WIDTH'(y);
  assign exp_sum  = golden_sum(x_ext, y_ext);
  assign got_sum  = (MAX_WIDTH+1)'({cout, s});
  assign mismatch = (got_sum != exp_sum);

`ifdef ADDER_SELFTEST_STOP_ON_ERR_EN
  assign stop_req = check_en && mismatch;
`else
  assign stop_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else if (clear) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else if (check_en && mismatch) begin
      // Width covers every vector failing, so this never wraps.
      err_count <= err_count + 1'b1;
      if (!first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_idx   <= idx;
      end
    end
  end

endmodule

// File: rtl/adder_selftest_seq.sv
// Exhaustive self-test sequencer: sweeps all {x,y} pairs (x major) into the adder and checks the sum.
// ADDER_SELFTEST_STOP_ON_ERR_EN: when defined, the sweep ends at the first mismatch.
//
// state  | meaning
// IDLE   | waiting for start after reset
// APPLY  | drive x_o/y_o from the vector index
// SETTLE | wait SETTLE_CYCLES for the adder to settle
// CHECK  | compare result, advance index or finish
// DONE   | results valid; start re-launches a sweep
module adder_selftest_seq
  import adder_selftest_pkg::*;
#(
  parameter int WIDTH         = 6,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  adder_selftest_seq_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2*WIDTH:0]    err_count,
  output logic                first_err_valid,
  output logic [2*WIDTH-1:0]  first_err_idx
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 0) ? SETTLE_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [2*WIDTH-1:0] LAST_IDX = '1;

  state_e               state_q;
  state_e               state_d;
  logic [2*WIDTH-1:0]   idx_q;
  logic [SETTLE_W-1:0]  settle_cnt_q;
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH-1:0]     y_q;
  logic                 clear;
  logic                 check_en;
  logic                 stop_req;
  logic                 last_vec;

  assign last_vec = (idx_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    check_en = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY;
          clear   = 1'b1;
        end
      end
      APPLY:  state_d = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
      SETTLE: if (settle_cnt_q == '0) state_d = CHECK;
      CHECK: begin
        check_en = 1'b1;
        state_d  = (last_vec || stop_req) ? DONE : APPLY;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Index and settle down-counter; operands stay registered so DONE shows the last vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      settle_cnt_q <= '0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) idx_q <= '0;
        end
        APPLY: begin
          x_q          <= idx_q[2*WIDTH-1:WIDTH];
          y_q          <= idx_q[WIDTH-1:0];
          settle_cnt_q <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt_q != '0) settle_cnt_q <= settle_cnt_q - 1'b1;
        end
        CHECK: begin
          if (!last_vec && !stop_req) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.x_o = x_q;
  assign bus.y_o = y_q;

  assign busy = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == '0);

  adder_result_checker #(
    .WIDTH (WIDTH)
  ) u_checker (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .check_en        (check_en),
    .x               (x_q),
    .y               (y_q),
    .s               (bus.s_i),
    .cout            (bus.cout_i),
    .idx             (idx_q),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx),
    .stop_req        (stop_req)
  );

endmodule

// File: tb/tb_adder_selftest_seq.sv
// Directed bench for adder_selftest_seq with a behavioural adder and injectable stuck-at faults.
module tb_adder_selftest_seq;

  localparam int W       = 6;
  localparam int TIMEOUT = 20000;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            done;
  logic            pass;
  logic [2*W:0]    err_count;
  logic            first_err_valid;
  logic [2*W-1:0]  first_err_idx;
  int              fault;
  int              n_checks;
  int              n_fail;

  adder_selftest_seq_if #(.WIDTH(W)) bus ();

  adder_selftest_seq #(
    .WIDTH         (W),
    .SETTLE_CYCLES (1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .bus             (bus),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_idx   (first_err_idx)
  );

  // 0: good adder, 1: S[0] stuck-at-0, 2: cout stuck-at-0
  logic [W:0] model_sum;
  always_comb begin
    model_sum = {1'b0, bus.x_o} + {1'b0, bus.y_o};
    if (fault == 1) model_sum[0] = 1'b0;
    if (fault == 2) model_sum[W] = 1'b0;
  end
  assign bus.s_i    = model_sum[W-1:0];
  assign bus.cout_i = model_sum[W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_sweep(input int pulse_at, output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 0;
    while (cycles < TIMEOUT) begin
      @(posedge clk);
      #1;
      cycles++;
      start = (cycles == pulse_at);
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.x_o !== 6'd0) begin n_fail++; $display("FAIL reset_x: got %0d expected 0", bus.x_o); end
    n_checks++; if (bus.y_o !== 6'd0) begin n_fail++; $display("FAIL reset_y: got %0d expected 0", bus.y_o); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %0b expected 0", pass); end
    n_checks++; if (err_count !== 13'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err_count); end
    n_checks++; if (first_err_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fev: got %0b expected 0", first_err_valid); end
    n_checks++; if (first_err_idx !== 12'd0) begin n_fail++; $display("FAIL reset_fei: got %0d expected 0", first_err_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got busy=%0b done=%0b expected 0 0", busy, done); end
  endtask

  task automatic test_clean_sweep();
    int cyc;
    fault = 0;
    run_sweep(0, cyc);
    n_checks++; if (cyc !== 12288) begin n_fail++; $display("FAIL clean_cycles: got %0d expected 12288", cyc); end
    n_checks++; if (err_count !== 13'd0) begin n_fail++; $display("FAIL clean_err: got %0d expected 0", err_count); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL clean_pass: got %0b expected 1", pass); end
    n_checks++; if (first_err_valid !== 1'b0) begin n_fail++; $display("FAIL clean_fev: got %0b expected 0", first_err_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clean_busy: got %0b expected 0", busy); end
    n_checks++; if (bus.x_o !== 6'd63 || bus.y_o !== 6'd63) begin n_fail++; $display("FAIL clean_last_vec: got x=%0d y=%0d expected 63 63", bus.x_o, bus.y_o); end
  endtask

  task automatic test_s0_stuck();
    int cyc;
    fault = 1;
    run_sweep(0, cyc);
`ifdef ADDER_SELFTEST_STOP_ON_ERR_EN
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL s0_cycles: got %0d expected 6", cyc); end
    n_checks++; if (err_count !== 13'd1) begin n_fail++; $display("FAIL s0_err: got %0d expected 1", err_count); end
    n_checks++; if (bus.x_o !== 6'd0 || bus.y_o !== 6'd1) begin n_fail++; $display("FAIL s0_vec: got x=%0d y=%0d expected 0 1", bus.x_o, bus.y_o); end
`else
    n_checks++; if (cyc !== 12288) begin n_fail++; $display("FAIL s0_cycles: got %0d expected 12288", cyc); end
    n_checks++; if (err_count !== 13'd2048) begin n_fail++; $display("FAIL s0_err: got %0d expected 2048", err_count); end
`endif
    n_checks++; if (first_err_valid !== 1'b1) begin n_fail++; $display("FAIL s0_fev: got %0b expected 1", first_err_valid); end
    n_checks++; if (first_err_idx !== 12'd1) begin n_fail++; $display("FAIL s0_fei: got %0d expected 1", first_err_idx); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL s0_pass: got %0b expected 0", pass); end
  endtask

  task automatic test_cout_stuck();
    int cyc;
    fault = 2;
    run_sweep(0, cyc);
`ifdef ADDER_SELFTEST_STOP_ON_ERR_EN
    n_checks++; if (cyc !== 384) begin n_fail++; $display("FAIL cout_cycles: got %0d expected 384", cyc); end
    n_checks++; if (err_count !== 13'd1) begin n_fail++; $display("FAIL cout_err: got %0d expected 1", err_count); end
`else
    n_checks++; if (cyc !== 12288) begin n_fail++; $display("FAIL cout_cycles: got %0d expected 12288", cyc); end
    n_checks++; if (err_count !== 13'd2016) begin n_fail++; $display("FAIL cout_err: got %0d expected 2016", err_count); end
`endif
    n_checks++; if (first_err_idx !== 12'd127) begin n_fail++; $display("FAIL cout_fei: got %0d expected 127", first_err_idx); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL cout_pass: got %0b expected 0", pass); end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    fault = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4999) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got busy=%0b done=%0b pass=%0b expected 0 0 0", busy, done, pass); end
    n_checks++; if (err_count !== 13'd0 || first_err_valid !== 1'b0 || first_err_idx !== 12'd0) begin n_fail++; $display("FAIL midrst_results: got err=%0d fev=%0b fei=%0d expected 0 0 0", err_count, first_err_valid, first_err_idx); end
    n_checks++; if (bus.x_o !== 6'd0 || bus.y_o !== 6'd0) begin n_fail++; $display("FAIL midrst_vec: got x=%0d y=%0d expected 0 0", bus.x_o, bus.y_o); end
    @(negedge clk);
    rst_n = 1'b1;
    fault = 0;
    run_sweep(0, cyc);
    n_checks++; if (cyc !== 12288) begin n_fail++; $display("FAIL midrst_cycles: got %0d expected 12288", cyc); end
    n_checks++; if (err_count !== 13'd0 || pass !== 1'b1) begin n_fail++; $display("FAIL midrst_sweep: got err=%0d pass=%0b expected 0 1", err_count, pass); end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    fault = 0;
    run_sweep(100, cyc);
    n_checks++; if (cyc !== 12288) begin n_fail++; $display("FAIL busy_start_cycles: got %0d expected 12288", cyc); end
    n_checks++; if (err_count !== 13'd0) begin n_fail++; $display("FAIL busy_start_err: got %0d expected 0", err_count); end
  endtask

  task automatic test_restart_in_done();
    int cyc;
    fault = 0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL restart_pre_done: got %0b expected 1", done); end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_drop: got done=%0b busy=%0b expected 0 1", done, busy); end
    cyc = 0;
    while (cyc < TIMEOUT) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
    n_checks++; if (cyc !== 12288) begin n_fail++; $display("FAIL restart_cycles: got %0d expected 12288", cyc); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL restart_pass: got %0b expected 1", pass); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    fault    = 0;
    start    = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_clean_sweep();
    test_s0_stuck();
    test_cout_stuck();
    test_reset_mid_sweep();
    test_start_while_busy();
    test_restart_in_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
